pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- XLEN, 32, PC width in bits.
- RESET_VECTOR, 32'h00400000, PC value loaded on reset.
- STEP, 4, sequential increment in bytes.
- ALIGN, 2, number of low target bits that must be zero.
- CNT_W, 16, fetch counter width.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state updates on its rising edge.
- rst_n, input, 1, synchronous, active-low reset.
- fetch_ready, input, 1, instruction memory accepts the current PC.
- stall, input, 1, freezes PC and state.
- redirect_valid, input, 1, branch/jump redirect request.
- redirect_target, input, XLEN, redirect destination.
- halt_req, input, 1, stop fetching after the current handshake.
- pc, output, XLEN, current fetch address.
- fetch_valid, output, 1, pc is a valid fetch request.
- misalign_err, output, 1, one-cycle pulse on a misaligned redirect.
- halted, output, 1, block is in HALT.
- fetch_cnt, output, CNT_W, count of completed handshakes.

Function
REQ-003 The block SHALL implement states BOOT, RUN, BUBBLE and HALT, with a single state register.
REQ-004 Handshake SHALL be defined as fire = fetch_valid & fetch_ready & ~stall.
REQ-005 fetch_valid SHALL be 1 only in RUN, and SHALL be 0 in BOOT, BUBBLE and HALT.
REQ-006 BOOT SHALL last exactly one cycle and then go to RUN, with pc unchanged.
REQ-007 In RUN, a fire without a redirect SHALL update pc to pc+STEP, truncated to XLEN bits (wraps from all-ones region to low addresses).
REQ-008 In RUN, when fetch_ready=0 and there is no redirect, pc and fetch_valid SHALL hold.
REQ-009 When redirect_valid=1 with an aligned target (low ALIGN bits zero) in RUN, BUBBLE or HALT, pc SHALL load redirect_target next cycle and state SHALL go to BUBBLE; a fire in the same cycle still counts, but the sequential increment is discarded.
REQ-010 BUBBLE SHALL last one cycle, then go to RUN; a new aligned redirect in BUBBLE SHALL reload pc and stay in BUBBLE.
REQ-011 A misaligned redirect SHALL leave pc unchanged, pulse misalign_err for exactly one cycle, and move state to HALT.
REQ-012 halt_req in RUN SHALL go to HALT:
- on the cycle of a fire, with pc advanced by STEP;
- immediately if there is no pending handshake (fetch_ready=0).
REQ-013 Priority SHALL be: rst_n low > stall > misaligned redirect > aligned redirect > halt_req > sequential.
REQ-014 HALT SHALL be left only by an aligned redirect; halted=1 exactly while in HALT.
REQ-015 stall=1 SHALL freeze pc, state and fetch_cnt, SHALL ignore redirect_valid and halt_req that cycle, and SHALL suppress misalign_err; fetch_valid keeps its state-based value.
REQ-016 fetch_cnt SHALL increment by 1 on each fire and wrap modulo 2^CNT_W.
REQ-017 All outputs SHALL be registered or decoded from state only, with no combinational path from inputs to outputs.

Reset
REQ-018 When rst_n=0 at a rising edge, the block SHALL set pc=RESET_VECTOR, state=BOOT, fetch_valid=0, misalign_err=0, halted=0 and fetch_cnt=0, regardless of other inputs.
REQ-019 Reset asserted mid-operation (RUN, BUBBLE or HALT) SHALL discard any pending redirect or halt, and SHALL restart from BOOT.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset then fetch_ready=1 constant -> cycle 0 pc=0x00400000 with fetch_valid=0; cycle 1 fetch_valid=1; then pc = 0x00400004, 0x00400008, and fetch_cnt counts 1, 2, 3.
- In RUN at pc=0x00400008, redirect to 0x00400100 -> next cycle pc=0x00400100 with fetch_valid=0 (BUBBLE); following cycle fetch_valid=1.
- Redirect to 0x00400102 -> pc holds, misalign_err=1 for one cycle, halted=1; then redirect to 0x00400200 -> BUBBLE, then RUN at 0x00400200.
- stall=1 for 3 cycles with fetch_ready=1 and redirect_valid=1 -> pc, fetch_cnt and state are unchanged, and no misalign_err.
- pc=0xFFFFFFFC with a fire -> pc=0x00000000, and fetch_cnt at 0xFFFF wraps to 0x0000.
- halt_req with fire at pc=0x00400010 -> halted=1 and pc=0x00400014; then rst_n=0 for one cycle -> pc=0x00400000, BOOT, halted=0.

Source files
------------

// File: rtl/pc_gen.sv
// Program counter generator: boot, sequential fetch, redirects, halt and a
// fetch handshake counter, all state held in registers.
module pc_gen #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = XLEN'(32'h0040_0000),
    parameter int unsigned          STEP         = 4,
    parameter int unsigned          ALIGN        = 2,
    parameter int unsigned          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_ready,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    input  logic             halt_req,
    output logic [XLEN-1:0]  pc,
    output logic             fetch_valid,
    output logic             misalign_err,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'(1) << ALIGN) - 64'(1));

    typedef enum logic [1:0] {BOOT, RUN, BUBBLE, HALT} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  w_pc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             r_fetch_valid;
    logic             r_halted;
    logic             w_fire;
    logic             w_misalign;
    logic             w_redirect;

    assign w_fire     = r_fetch_valid & fetch_ready & ~stall;
    assign w_misalign = redirect_valid & (|(redirect_target & ALIGN_MASK));
    assign w_redirect = redirect_valid & ~w_misalign;

    // Next state, pc, error pulse and counter; stall holds everything.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt + CNT_W'(w_fire);
        if (!stall) begin
            case (r_state)
                BOOT: begin
                    w_state_nxt = RUN;
                end
                RUN, BUBBLE, HALT: begin
                    if (w_misalign) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = HALT;
                    end else if (w_redirect) begin
                        w_pc_nxt    = redirect_target;
                        w_state_nxt = BUBBLE;
                    end else if (r_state == RUN) begin
                        if (w_fire) begin
                            w_pc_nxt = r_pc + XLEN'(STEP);
                        end
                        if (halt_req) begin
                            w_state_nxt = HALT;
                        end
                    end else if (r_state == BUBBLE) begin
                        w_state_nxt = RUN;
                    end
                end
                default: begin
                    w_state_nxt = BOOT;
                end
            endcase
        end
    end

    // State register; valid/halted flags are registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_cnt         <= '0;
            r_err         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_err         <= w_err_nxt;
            r_fetch_valid <= (w_state_nxt == RUN);
            r_halted      <= (w_state_nxt == HALT);
        end
    end

    assign pc           = r_pc;
    assign fetch_valid  = r_fetch_valid;
    assign misalign_err = r_err;
    assign halted       = r_halted;
    assign fetch_cnt    = r_cnt;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and random checks of pc_gen against a behavioural fetch model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic [31:0] pc;
    logic        fetch_valid;
    logic        misalign_err;
    logic        halted;
    logic [15:0] fetch_cnt;

    int n_checks = 0;
    int n_err    = 0;

    typedef enum int {M_BOOT, M_RUN, M_BUB, M_HALT} mode_e;
    mode_e       m_mode;
    logic [31:0] m_pc;
    logic [15:0] m_cnt;
    logic        m_err;

    pc_gen dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_ready     (fetch_ready),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .pc              (pc),
        .fetch_valid     (fetch_valid),
        .misalign_err    (misalign_err),
        .halted          (halted),
        .fetch_cnt       (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model applies the behavioural rules to the inputs at the edge.
    task automatic tick();
        bit fire;
        @(posedge clk);
        if (!rst_n) begin
            m_mode = M_BOOT; m_pc = 32'h0040_0000; m_cnt = 16'h0; m_err = 1'b0;
        end else if (stall) begin
            m_err = 1'b0;
        end else begin
            fire  = (m_mode == M_RUN) && fetch_ready;
            m_cnt = 16'((32'(m_cnt) + (fire ? 1 : 0)) % 65536);
            m_err = 1'b0;
            if (m_mode == M_BOOT) begin
                m_mode = M_RUN;
            end else if (redirect_valid && (redirect_target % 4 != 0)) begin
                m_err  = 1'b1;
                m_mode = M_HALT;
            end else if (redirect_valid) begin
                m_pc   = redirect_target;
                m_mode = M_BUB;
            end else if (m_mode == M_RUN) begin
                if (fire) m_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
                if (halt_req) m_mode = M_HALT;
            end else if (m_mode == M_BUB) begin
                m_mode = M_RUN;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"}, pc, m_pc);
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_mode == M_RUN));
        chk({tag, ".halted"}, 32'(halted), 32'(m_mode == M_HALT));
        chk({tag, ".misalign_err"}, 32'(misalign_err), 32'(m_err));
        chk({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(m_cnt));
    endtask

    initial begin
        logic [31:0] t;
        int          guard;
        rst_n = 1'b0; fetch_ready = 1'b0; stall = 1'b0;
        redirect_valid = 1'b0; redirect_target = 32'h0; halt_req = 1'b0;
        m_mode = M_BOOT; m_pc = 32'h0; m_cnt = 16'h0; m_err = 1'b0;
        tick(); tick();
        check_model("reset");
        chk("reset.pc_const", pc, 32'h0040_0000);
        chk("reset.valid_const", 32'(fetch_valid), 32'd0);

        // Boot then sequential fetch
        rst_n = 1'b1; fetch_ready = 1'b1;
        tick(); check_model("boot");
        chk("boot.valid", 32'(fetch_valid), 32'd1);
        chk("boot.pc", pc, 32'h0040_0000);
        tick(); check_model("seq1");
        chk("seq1.pc", pc, 32'h0040_0004);
        chk("seq1.cnt", 32'(fetch_cnt), 32'd1);
        tick(); check_model("seq2");
        chk("seq2.pc", pc, 32'h0040_0008);
        chk("seq2.cnt", 32'(fetch_cnt), 32'd2);

        // Aligned redirect with a simultaneous fire
        redirect_valid = 1'b1; redirect_target = 32'h0040_0100;
        tick(); check_model("redir");
        chk("redir.pc", pc, 32'h0040_0100);
        chk("redir.valid", 32'(fetch_valid), 32'd0);
        chk("redir.cnt", 32'(fetch_cnt), 32'd3);
        redirect_valid = 1'b0; fetch_ready = 1'b0;
        tick(); check_model("bubble_out");
        chk("bubble_out.valid", 32'(fetch_valid), 32'd1);

        // Misaligned redirect, then recovery
        redirect_valid = 1'b1; redirect_target = 32'h0040_0102;
        tick(); check_model("misal");
        chk("misal.pc", pc, 32'h0040_0100);
        chk("misal.err", 32'(misalign_err), 32'd1);
        chk("misal.halted", 32'(halted), 32'd1);
        redirect_valid = 1'b0;
        tick(); check_model("misal_pulse");
        chk("misal_pulse.err", 32'(misalign_err), 32'd0);
        redirect_valid = 1'b1; redirect_target = 32'h0040_0200;
        tick(); check_model("recover");
        chk("recover.pc", pc, 32'h0040_0200);
        chk("recover.halted", 32'(halted), 32'd0);
        redirect_valid = 1'b0;
        tick(); check_model("recover_run");
        chk("recover_run.valid", 32'(fetch_valid), 32'd1);

        // Stall freezes everything and ignores redirect/halt
        stall = 1'b1; fetch_ready = 1'b1; redirect_valid = 1'b1; halt_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            redirect_target = (i == 1) ? 32'h0040_0300 : 32'h0040_0302;
            tick(); check_model("stall");
            chk("stall.pc", pc, 32'h0040_0200);
            chk("stall.cnt", 32'(fetch_cnt), 32'd3);
            chk("stall.err", 32'(misalign_err), 32'd0);
            chk("stall.valid", 32'(fetch_valid), 32'd1);
        end
        stall = 1'b0; halt_req = 1'b0;

        // PC wrap and counter wrap
        redirect_target = 32'hFFFF_FFFC;
        tick(); redirect_valid = 1'b0;
        tick(); check_model("pre_wrap");
        chk("pre_wrap.pc", pc, 32'hFFFF_FFFC);
        tick(); check_model("pc_wrap");
        chk("pc_wrap.pc", pc, 32'h0000_0000);
        guard = 0;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            tick(); guard++;
        end
        check_model("cnt_max");
        chk("cnt_max.cnt", 32'(fetch_cnt), 32'h0000_FFFF);
        tick(); check_model("cnt_wrap");
        chk("cnt_wrap.cnt", 32'(fetch_cnt), 32'h0000_0000);

        // Halt on a fire, then reset with pending requests
        redirect_valid = 1'b1; redirect_target = 32'h0040_0010;
        tick(); redirect_valid = 1'b0;
        tick(); check_model("pre_halt");
        halt_req = 1'b1;
        tick(); check_model("halt");
        chk("halt.halted", 32'(halted), 32'd1);
        chk("halt.pc", pc, 32'h0040_0014);
        rst_n = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0040_0500;
        tick(); check_model("mid_reset");
        chk("mid_reset.pc", pc, 32'h0040_0000);
        chk("mid_reset.halted", 32'(halted), 32'd0);
        chk("mid_reset.valid", 32'(fetch_valid), 32'd0);
        rst_n = 1'b1; redirect_valid = 1'b0; halt_req = 1'b0; fetch_ready = 1'b0;
        tick(); check_model("reboot");
        chk("reboot.valid", 32'(fetch_valid), 32'd1);
        halt_req = 1'b1;
        tick(); check_model("halt_idle");
        chk("halt_idle.halted", 32'(halted), 32'd1);
        chk("halt_idle.pc", pc, 32'h0040_0000);
        halt_req = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 63) != 0);
            stall          = ($urandom_range(0, 3) == 0);
            fetch_ready    = $urandom_range(0, 1) == 1;
            redirect_valid = ($urandom_range(0, 7) == 0);
            halt_req       = ($urandom_range(0, 15) == 0);
            t = 32'h0040_0000 + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
            redirect_target = t;
            tick(); check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
